ifetch: RTL
===========

IFETCH -- requirements
Module: ifetch

Interface
REQ-001 Parameter RESET_PC, default 32'h8000_0000, first fetch address after reset.
REQ-002 Parameter INST_NOP, default 32'h0000_0013, bubble instruction driven when no fetch is delivered.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 hold_flag_i  input  1  pipeline stall from ctrl.
REQ-006 jump_flag_i  input  1  redirect request from ctrl/ex.
REQ-007 jump_addr_i  input  32  redirect target, word-aligned.
REQ-008 imem_req_o  output  1  instruction-memory request valid.
REQ-009 imem_addr_o  output  32  request address.
REQ-010 imem_gnt_i  input  1  request accepted this cycle.
REQ-011 imem_rvalid_i  input  1  response data valid.
REQ-012 imem_rdata_i  input  32  response instruction.
REQ-013 inst_o  output  32  instruction to if_id.
REQ-014 inst_addr_o  output  32  PC of inst_o, to if_id.
REQ-015 inst_valid_o  output  1  one-cycle pulse per delivered instruction.

Function
REQ-016 Internal state: pc (32b), state in {S_REQ, S_WAIT, S_HOLD}, kill (1b), buf_inst/buf_addr (32b each); at most one outstanding imem request.
REQ-017 imem_req_o = 1 only in S_REQ; imem_addr_o = pc in S_REQ, else don't-care (drive pc).
REQ-018 S_REQ, gnt=1, no jump: go S_WAIT, kill=0, pc unchanged.
REQ-019 S_REQ, jump=1, gnt=0: pc<=jump_addr_i, stay S_REQ.
REQ-020 S_REQ, jump=1 and gnt=1 same cycle: go S_WAIT, kill<=1, pc<=jump_addr_i.
REQ-021 S_REQ: imem_rvalid_i ignored (stale response after reset/redirect is dropped).
REQ-022 S_WAIT, rvalid=0, jump=1: kill<=1, pc<=jump_addr_i, stay S_WAIT.
REQ-023 S_WAIT, rvalid=1, (kill=1 or jump=1): discard data, kill<=0, pc<=jump_addr_i if jump=1, go S_REQ.
REQ-024 S_WAIT, rvalid=1, kill=0, jump=0, hold=0: deliver imem_rdata_i with address pc, pc<=pc+4, go S_REQ.
REQ-025 S_WAIT, rvalid=1, kill=0, jump=0, hold=1: buf_inst<=rdata, buf_addr<=pc, go S_HOLD, no delivery.
REQ-026 S_HOLD, jump=1: drop buffer, pc<=jump_addr_i, go S_REQ (jump beats hold).
REQ-027 S_HOLD, jump=0, hold=0: deliver buf_inst/buf_addr, pc<=buf_addr+4, go S_REQ.
REQ-028 S_HOLD, jump=0, hold=1: stay, buffer stable.
REQ-029 Outputs registered: on a delivering edge inst_o/inst_addr_o/inst_valid_o <= instruction/address/1; on every other edge <= INST_NOP/32'h0/0.
REQ-030 Delivery latency: earliest inst_valid_o one edge after the rvalid edge; steady throughput one instruction per 2 cycles with gnt=1 and rvalid on the cycle after gnt.
REQ-031 pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-032 No instruction from a path older than the most recent jump is ever delivered.

Reset
REQ-033 rst=0 at an edge: pc<=RESET_PC, state<=S_REQ, kill<=0, buffer<=0, inst_o<=INST_NOP, inst_addr_o<=0, inst_valid_o<=0; overrides all other inputs.
REQ-034 Reset mid-S_WAIT: returns to S_REQ at RESET_PC; late rvalid for the old request ignored per REQ-021.

Verification
REQ-035 Reset release, gnt=1 always, rvalid one cycle after gnt, rdata=addr -> deliveries 80000000, 80000004, 80000008 each with valid pulse, NOP between.
REQ-036 Jump to 32'h8000_0100 in S_WAIT before rvalid -> response for old pc dropped, next request addr 80000100, next delivery inst_addr_o=80000100.
REQ-037 Jump coincident with gnt -> kill set, that response dropped, following request at jump_addr_i.
REQ-038 hold=1 for 3 cycles spanning rvalid -> no valid pulse while held; on hold release one pulse with buffered inst, then fetch continues at buf_addr+4.
REQ-039 hold=1 and jump=1 in S_HOLD -> buffer dropped, no delivery, request at jump_addr_i.
REQ-040 rst=0 asserted in S_WAIT, rvalid arrives after release -> ignored, request at 80000000, outputs NOP/0/0 during reset.

Source files
------------

// File: rtl/ifetch.sv
// Instruction fetch stage: issues one imem request at a time, drops responses
// from paths older than the latest redirect, and buffers a response across a stall.
module ifetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter logic [31:0] INST_NOP = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hold_flag_i,
    input  logic        jump_flag_i,
    input  logic [31:0] jump_addr_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o,
    output logic        inst_valid_o
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      state, state_n;
    logic [31:0] pc, pc_n;
    logic        kill, kill_n;
    logic [31:0] buf_inst, buf_inst_n;
    logic [31:0] buf_addr, buf_addr_n;
    logic        deliver;
    logic [31:0] deliver_inst;
    logic [31:0] deliver_addr;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= S_REQ;
            pc           <= RESET_PC;
            kill         <= 1'b0;
            buf_inst     <= 32'h0;
            buf_addr     <= 32'h0;
            inst_o       <= INST_NOP;
            inst_addr_o  <= 32'h0;
            inst_valid_o <= 1'b0;
        end else begin
            state        <= state_n;
            pc           <= pc_n;
            kill         <= kill_n;
            buf_inst     <= buf_inst_n;
            buf_addr     <= buf_addr_n;
            inst_o       <= deliver ? deliver_inst : INST_NOP;
            inst_addr_o  <= deliver ? deliver_addr : 32'h0;
            inst_valid_o <= deliver;
        end
    end

    // kill marks the outstanding response as belonging to a superseded path
    always_comb begin
        state_n      = state;
        pc_n         = pc;
        kill_n       = kill;
        buf_inst_n   = buf_inst;
        buf_addr_n   = buf_addr;
        deliver      = 1'b0;
        deliver_inst = INST_NOP;
        deliver_addr = 32'h0;

        case (state)
            S_REQ: begin
                if (imem_gnt_i) begin
                    state_n = S_WAIT;
                    kill_n  = jump_flag_i;
                end
                if (jump_flag_i) begin
                    pc_n = jump_addr_i;
                end
            end
            S_WAIT: begin
                if (imem_rvalid_i) begin
                    if (kill || jump_flag_i) begin
                        kill_n  = 1'b0;
                        state_n = S_REQ;
                        if (jump_flag_i) begin
                            pc_n = jump_addr_i;
                        end
                    end else if (hold_flag_i) begin
                        buf_inst_n = imem_rdata_i;
                        buf_addr_n = pc;
                        state_n    = S_HOLD;
                    end else begin
                        deliver      = 1'b1;
                        deliver_inst = imem_rdata_i;
                        deliver_addr = pc;
                        pc_n         = pc + 32'd4;
                        state_n      = S_REQ;
                    end
                end else if (jump_flag_i) begin
                    kill_n = 1'b1;
                    pc_n   = jump_addr_i;
                end
            end
            S_HOLD: begin
                if (jump_flag_i) begin
                    pc_n    = jump_addr_i;
                    state_n = S_REQ;
                end else if (!hold_flag_i) begin
                    deliver      = 1'b1;
                    deliver_inst = buf_inst;
                    deliver_addr = buf_addr;
                    pc_n         = buf_addr + 32'd4;
                    state_n      = S_REQ;
                end
            end
            default: begin
                state_n = S_REQ;
            end
        endcase
    end

    assign imem_req_o  = (state == S_REQ);
    assign imem_addr_o = pc;

endmodule
